// File: rtl/sfx_pkg.sv
// Shared definitions for the multi-voice sound-effect scheduler:
// sequencer states, register map and CTRL bit positions.
package sfx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ACCUM,
        ST_OUT
    } state_e;

    localparam logic [1:0] REG_START   = 2'd0;
    localparam logic [1:0] REG_LEN     = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_IRQ_CLR = 2'd3;

    localparam int CTRL_GO   = 0;
    localparam int CTRL_LOOP = 1;
    localparam int CTRL_STOP = 2;

    // Clamp a wide signed mix into the 16-bit signed output range.
    function automatic logic [15:0] sat16(input int value);
        if (value > 32767) begin
            return 16'h7FFF;
        end else if (value < -32768) begin
            return 16'h8000;
        end else begin
            return value[15:0];
        end
    endfunction

endpackage

// File: rtl/sfx_voice.sv
// One playback voice: START/LEN/LOOP registers, play position, active/done
// flags and the GO/STOP commands held until the sequencer is idle.
module sfx_voice
    import sfx_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [1:0]        wr_reg_i,
    input  logic [15:0]       wr_data_i,
    input  logic              apply_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              active_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] start_q, start_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       pos_q, pos_d;
    logic              loop_q, loop_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              pend_go_q, pend_go_d;
    logic              pend_stop_q, pend_stop_d;
    logic              last_sample;

    assign last_sample = (pos_q == len_q - 16'd1);

    // NOTE: every _d gets its _q value first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        start_d     = start_q;
        len_d       = len_q;
        pos_d       = pos_q;
        loop_d      = loop_q;
        active_d    = active_q;
        done_d      = done_q;
        pend_go_d   = pend_go_q;
        pend_stop_d = pend_stop_q;

        if (wr_en_i && wr_reg_i == REG_START) begin
            start_d = wr_data_i[ADDR_W-1:0];
        end
        if (wr_en_i && wr_reg_i == REG_LEN) begin
            len_d = wr_data_i;
        end

        // STOP has priority over GO; GO on an empty sound is dropped.
        if (apply_i) begin
            pend_go_d   = 1'b0;
            pend_stop_d = 1'b0;
            if (pend_stop_q) begin
                active_d = 1'b0;
            end else if (pend_go_q && len_q != 16'd0) begin
                active_d = 1'b1;
                pos_d    = 16'd0;
            end
        end

        // A command arriving in the same cycle as the apply is kept for later.
        if (wr_en_i && wr_reg_i == REG_CTRL) begin
            loop_d      = wr_data_i[CTRL_LOOP];
            pend_go_d   = pend_go_d | wr_data_i[CTRL_GO];
            pend_stop_d = pend_stop_d | wr_data_i[CTRL_STOP];
        end

        if (wr_en_i && wr_reg_i == REG_IRQ_CLR) begin
            done_d = 1'b0;
        end

        if (step_i) begin
            if (last_sample) begin
                if (loop_q) begin
                    pos_d = 16'd0;
                end else begin
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end
            end else begin
                pos_d = pos_q + 16'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q     <= '0;
            len_q       <= '0;
            pos_q       <= '0;
            loop_q      <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            pend_go_q   <= 1'b0;
            pend_stop_q <= 1'b0;
        end else begin
            start_q     <= start_d;
            len_q       <= len_d;
            pos_q       <= pos_d;
            loop_q      <= loop_d;
            active_q    <= active_d;
            done_q      <= done_d;
            pend_go_q   <= pend_go_d;
            pend_stop_q <= pend_stop_d;
        end
    end

    assign addr_o   = start_q + pos_q[ADDR_W-1:0];
    assign active_o = active_q;
    assign done_o   = done_q;

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler top: per-sample walk over the voices, shared ROM
// address mux, saturating mixer and register-write decode.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int ADDR_W      = 15,
    parameter int ROM_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            chipselect,
    input  logic                            write,
    input  logic [$clog2(NUM_VOICES)+1:0]   address,
    input  logic [15:0]                     writedata,
    output logic                            irq,
    input  logic                            sample_req,
    output logic [ADDR_W-1:0]               rom_addr,
    input  logic [15:0]                     rom_q,
    output logic [15:0]                     audio_output,
    output logic [NUM_VOICES-1:0]           voice_active
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = 16 + VW;

    state_e                   state_q, state_d;
    logic [VW-1:0]            v_q, v_d;
    logic [7:0]               wait_cnt_q, wait_cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [15:0]              audio_q, audio_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;

    logic [ADDR_W-1:0]        voice_addr [NUM_VOICES];
    logic [NUM_VOICES-1:0]    active;
    logic [NUM_VOICES-1:0]    done;
    logic                     wr_en;
    logic [VW-1:0]            wr_voice;
    logic [1:0]               wr_reg;
    logic                     last_voice;

    assign wr_en      = chipselect && write;
    assign wr_voice   = address[VW+1:2];
    assign wr_reg     = address[1:0];
    assign last_voice = (v_q == VW'(NUM_VOICES - 1));

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        sfx_voice #(
            .ADDR_W (ADDR_W)
        ) u_voice (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (wr_en && wr_voice == VW'(g)),
            .wr_reg_i  (wr_reg),
            .wr_data_i (writedata),
            .apply_i   (state_q == ST_IDLE),
            .step_i    (state_q == ST_ACCUM && v_q == VW'(g)),
            .addr_o    (voice_addr[g]),
            .active_o  (active[g]),
            .done_o    (done[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        wait_cnt_d = wait_cnt_q;
        acc_d      = acc_q;
        audio_d    = audio_q;
        rom_addr_d = rom_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_req) begin
                    acc_d   = '0;
                    v_d     = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (active[v_q]) begin
                    rom_addr_d = voice_addr[v_q];
                    wait_cnt_d = '0;
                    state_d    = (ROM_LATENCY > 1) ? ST_WAIT : ST_ACCUM;
                end else if (last_voice) begin
                    state_d = ST_OUT;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 8'(ROM_LATENCY - 2)) begin
                    state_d = ST_ACCUM;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + {{VW{rom_q[15]}}, rom_q};
                if (last_voice) begin
                    state_d = ST_OUT;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_OUT: begin
                audio_d = sat16(int'(acc_q));
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            v_q        <= '0;
            wait_cnt_q <= '0;
            acc_q      <= '0;
            audio_q    <= '0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            wait_cnt_q <= wait_cnt_d;
            acc_q      <= acc_d;
            audio_q    <= audio_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // The ROM sees the fetch address during FETCH itself, so the word is
    // ready exactly when ACCUM samples rom_q.
    assign rom_addr     = rom_addr_d;
    assign audio_output = audio_q;
    assign irq          = |done;
    assign voice_active = active;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench for sfx_scheduler: directed scenarios plus randomized
// register/sample traffic compared against a per-voice playback model.
module tb_sfx_scheduler;

    localparam int N   = 4;
    localparam int AW  = 15;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          chipselect;
    logic          write;
    logic [3:0]    address;
    logic [15:0]   writedata;
    logic          irq;
    logic          sample_req;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_q;
    logic [15:0]   audio_output;
    logic [N-1:0]  voice_active;

    sfx_scheduler #(
        .NUM_VOICES  (N),
        .ADDR_W      (AW),
        .ROM_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .chipselect   (chipselect),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .irq          (irq),
        .sample_req   (sample_req),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .audio_output (audio_output),
        .voice_active (voice_active)
    );

    always #5 clk = ~clk;

    // Two-register synchronous ROM.
    logic [15:0] rom_mem [0:(1<<AW)-1];
    logic [15:0] rom_pipe;
    always @(posedge clk) begin
        rom_pipe <= rom_mem[rom_addr];
        rom_q    <= rom_pipe;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_start [N];
    int m_len   [N];
    int m_pos   [N];
    bit m_loop  [N];
    bit m_act   [N];
    bit m_done  [N];
    bit m_pgo   [N];
    bit m_pstop [N];
    int m_audio;
    int m_last_addr;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_start[i] = 0; m_len[i] = 0; m_pos[i] = 0; m_loop[i] = 0;
            m_act[i] = 0; m_done[i] = 0; m_pgo[i] = 0; m_pstop[i] = 0;
        end
        m_audio     = 0;
        m_last_addr = 0;
    endtask

    task automatic m_apply();
        for (int i = 0; i < N; i++) begin
            if (m_pstop[i]) m_act[i] = 0;
            else if (m_pgo[i] && m_len[i] != 0) begin
                m_act[i] = 1;
                m_pos[i] = 0;
            end
            m_pgo[i]   = 0;
            m_pstop[i] = 0;
        end
    endtask

    task automatic m_write(input int v, input int r, input int data);
        case (r)
            0: m_start[v] = data & 32'h7FFF;
            1: m_len[v]   = data & 32'hFFFF;
            2: begin
                m_loop[v]  = data[1];
                m_pgo[v]   = m_pgo[v] | data[0];
                m_pstop[v] = m_pstop[v] | data[2];
            end
            default: m_done[v] = 0;
        endcase
    endtask

    // Mix one sample from the voices' rules; returns the expected latency.
    task automatic m_sample(output int lat);
        int sum, k, a;
        logic signed [15:0] w;
        m_apply();
        sum = 0;
        k   = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                k++;
                a = (m_start[i] + m_pos[i]) % (1 << AW);
                w = rom_mem[a];
                sum += int'(w);
                m_last_addr = a;
                if (m_pos[i] == ((m_len[i] - 1) & 32'hFFFF)) begin
                    if (m_loop[i]) m_pos[i] = 0;
                    else begin
                        m_act[i]  = 0;
                        m_done[i] = 1;
                    end
                end else begin
                    m_pos[i] = (m_pos[i] + 1) & 32'hFFFF;
                end
            end
        end
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        m_audio = sum & 32'hFFFF;
        lat = 2 + (N - k) + k * (LAT + 1);
    endtask

    function automatic logic m_irq();
        logic r = 1'b0;
        for (int i = 0; i < N; i++) r |= m_done[i];
        return r;
    endfunction

    function automatic logic [N-1:0] m_va();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_act[i];
        return r;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".audio"}, audio_output, m_audio);
        check({tag, ".irq"}, irq, m_irq());
        check({tag, ".active"}, voice_active, m_va());
        check({tag, ".rom_addr"}, rom_addr, m_last_addr);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic reg_write(input int v, input int r, input int data);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 4'(v * 4 + r);
        writedata  = 16'(data);
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        m_write(v, r, data);
        m_apply();
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_sample(input string tag);
        int lat, old;
        old = m_audio;
        m_sample(lat);
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        repeat (lat - 2) @(negedge clk);
        if (old != m_audio) check({tag, ".early"}, audio_output, old);
        @(negedge clk);
        check_all(tag);
    endtask

    int lat;
    int exp_single [4] = '{10, 20, 30, 0};
    int exp_loop   [5] = '{32'h7FFE, 32'h7FFF, 32'h0000, 32'h0001, 32'h7FFE};

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        sample_req = 1'b0;
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 16'($urandom);
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all("reset");

        // Single voice, three samples then silence.
        rom_mem[16'h100] = 16'd10;
        rom_mem[16'h101] = 16'd20;
        rom_mem[16'h102] = 16'd30;
        reg_write(0, 0, 16'h0100);
        reg_write(0, 1, 3);
        reg_write(0, 2, 1);
        settle("single_go");
        for (int i = 0; i < 4; i++) begin
            do_sample($sformatf("single%0d", i));
            check($sformatf("single%0d.value", i), audio_output, exp_single[i]);
            if (i == 2) check("single.irq_set", irq, 1);
        end
        reg_write(0, 3, 0);
        settle("single_clr");
        check("single.irq_clr", irq, 0);

        // Looping voice wrapping across the top of the ROM.
        reg_write(1, 0, 16'h7FFE);
        reg_write(1, 1, 4);
        reg_write(1, 2, 3);
        for (int i = 0; i < 5; i++) begin
            do_sample($sformatf("loop%0d", i));
            check($sformatf("loop%0d.addr", i), rom_addr, exp_loop[i]);
        end
        reg_write(1, 2, 4);
        settle("loop_stop");

        // Saturation in both directions.
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < N; v++) begin
                rom_mem[16'h200 + 16 * v] = (pass == 0) ? 16'h7000 : 16'h9000;
                reg_write(v, 0, 16'h200 + 16 * v);
                reg_write(v, 1, 1);
                reg_write(v, 2, 1);
            end
            do_sample($sformatf("sat%0d", pass));
            check($sformatf("sat%0d.value", pass), audio_output, (pass == 0) ? 32'h7FFF : 32'h8000);
            for (int v = 0; v < N; v++) reg_write(v, 3, 0);
            settle($sformatf("sat%0d_clr", pass));
        end

        // Request during FETCH is ignored; GO during a sequence waits for IDLE.
        reg_write(0, 0, 16'h0300);
        reg_write(0, 1, 2);
        reg_write(0, 2, 3);
        reg_write(3, 0, 16'h0400);
        reg_write(3, 1, 3);
        m_sample(lat);
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 4'(3 * 4 + 2);
        writedata  = 16'h0001;
        @(negedge clk);
        sample_req = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        m_write(3, 2, 1);
        repeat (lat - 2) @(negedge clk);
        check("midgo.audio", audio_output, m_audio);
        check("midgo.not_yet", voice_active[3], 0);
        @(negedge clk);
        m_apply();
        check_all("midgo.applied");
        repeat (20) @(negedge clk);
        check_all("midgo.no_restart");

        // GO+STOP together, and GO on an empty sound.
        reg_write(2, 1, 2);
        reg_write(2, 2, 5);
        settle("gostop");
        check("gostop.inactive", voice_active[2], 0);
        reg_write(2, 1, 0);
        reg_write(2, 2, 1);
        settle("len0");
        check("len0.inactive", voice_active[2], 0);
        do_sample("after_timing0");
        do_sample("after_timing1");

        // Reset while the sequencer waits on the ROM; pending GO is lost.
        reg_write(1, 1, 4);
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 4'(1 * 4 + 2);
        writedata  = 16'h0001;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        check_all("midreset");
        repeat (3) @(negedge clk);
        check_all("midreset.settled");
        reg_write(0, 0, 16'h0100);
        reg_write(0, 1, 3);
        reg_write(0, 2, 1);
        do_sample("postreset");
        check("postreset.value", audio_output, 10);

        // Randomized register and sample traffic.
        for (int it = 0; it < 300; it++) begin
            int op, v, data;
            op = $urandom_range(0, 9);
            v  = $urandom_range(0, N - 1);
            case (op)
                0:       data = $urandom_range(0, 16'hFFFF);
                1, 2:    data = $urandom_range(0, 5);
                3, 4:    data = $urandom_range(0, 7);
                5:       data = 0;
                default: data = 0;
            endcase
            if (op <= 5) begin
                reg_write(v, (op == 0) ? 0 : (op <= 2) ? 1 : (op <= 4) ? 2 : 3, data);
                settle($sformatf("rnd%0d.wr", it));
            end else begin
                do_sample($sformatf("rnd%0d.smp", it));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
